// File: rtl/regfile_pkg.sv
// Shared definitions for the pipelined register file: soft-clear FSM states,
// the hardwired zero register index and default geometry.
package regfile_pkg;

  localparam int DEF_XLEN = 32;
  localparam int DEF_NREG = 32;
  localparam int ZERO_REG = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port with write-first bypass (W0 over W1 over array)
// and a pending flag that drops when the load data is returning this cycle.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] row_data,
  input  logic            row_pend,
  input  logic            bypass_en,
  input  logic            w0_en,
  input  logic [AW-1:0]   w0_addr,
  input  logic [XLEN-1:0] w0_data,
  input  logic            w1_en,
  input  logic [AW-1:0]   w1_addr,
  input  logic [XLEN-1:0] w1_data,
  output logic [XLEN-1:0] data,
  output logic            pend
);

  // Select the newest value for this address; x0 always reads as zero and never pending
  always_comb begin
    data = row_data;
    pend = row_pend && !(w1_en && (w1_addr == addr));
    if (addr == AW'(ZERO_REG)) begin
      data = '0;
      pend = 1'b0;
    end else if (bypass_en && w0_en && (w0_addr == addr)) begin
      data = w0_data;
    end else if (bypass_en && w1_en && (w1_addr == addr)) begin
      data = w1_data;
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file for the pipelined core: NRD bypassing read ports,
// ALU (W0) and load-return (W1) write ports, a pending-load scoreboard and a
// sequential soft-clear engine that zeroes one register per cycle.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int NREG = DEF_NREG,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic                clk,
  input  logic                areset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pend,
  input  logic                w0_en,
  input  logic [AW-1:0]       w0_addr,
  input  logic [XLEN-1:0]     w0_data,
  input  logic                w1_en,
  input  logic [AW-1:0]       w1_addr,
  input  logic [XLEN-1:0]     w1_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  input  logic                clr_req,
  output logic                clr_busy
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  clr_state_t      state;
  clr_state_t      state_next;
  logic [AW-1:0]   clr_cnt;
  logic            idle;
  logic            w0_we;
  logic            w1_we;
  logic            pend_clr;
  logic            pend_set;

  // Writes and scoreboard updates only happen while the clear engine is idle;
  // a W1 write colliding with W0 on the same register loses its data
  assign idle     = (state == IDLE);
  assign w0_we    = idle && w0_en && (w0_addr != ZERO_IDX);
  assign w1_we    = idle && w1_en && (w1_addr != ZERO_IDX) && !(w0_we && (w0_addr == w1_addr));
  assign pend_clr = idle && w1_en && (w1_addr != ZERO_IDX);
  assign pend_set = idle && iss_valid && (iss_rd != ZERO_IDX);

  // Soft-clear state register
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_next;
  end

  // Soft-clear next state; leave CLEAR once the last register is being zeroed
  always_comb begin
    state_next = state;
    clr_busy   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) state_next = CLEAR;
      end
      CLEAR: begin
        clr_busy = 1'b1;
        if (clr_cnt == LAST_IDX) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear index: starts at 1 because x0 is already zero, parks at 0 on exit
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      clr_cnt <= '0;
    end else if (idle) begin
      if (clr_req) clr_cnt <= AW'(1);
    end else begin
      clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + AW'(1);
    end
  end

  // Register array: normal writeback when idle, one row zeroed per cycle when clearing
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (idle) begin
      if (w0_we) regs[w0_addr] <= w0_data;
      if (w1_we) regs[w1_addr] <= w1_data;
    end else begin
      regs[clr_cnt] <= '0;
    end
  end

  // Pending scoreboard: a clear request wipes it, otherwise issue-set beats return-clear
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pend <= '0;
    end else if (idle) begin
      if (clr_req) begin
        pend <= '0;
      end else begin
        if (pend_clr) pend[w1_addr] <= 1'b0;
        if (pend_set) pend[iss_rd]  <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr_k;
    assign addr_k = ra[k*AW +: AW];

    regfile_rd_port #(
      .XLEN(XLEN),
      .AW  (AW)
    ) u_port (
      .addr     (addr_k),
      .row_data (regs[addr_k]),
      .row_pend (pend[addr_k]),
      .bypass_en(idle),
      .w0_en    (w0_en),
      .w0_addr  (w0_addr),
      .w0_data  (w0_data),
      .w1_en    (w1_en),
      .w1_addr  (w1_addr),
      .w1_data  (w1_data),
      .data     (rd_data[k*XLEN +: XLEN]),
      .pend     (rd_pend[k])
    );
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios followed by random
// traffic, all compared against an array/flag reference model of the register file.
module tb_regfile_mp_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                areset;
  logic [NRD*AW-1:0]   ra;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pend;
  logic                w0_en, w1_en, iss_valid, clr_req, clr_busy;
  logic [AW-1:0]       w0_addr, w1_addr, iss_rd;
  logic [XLEN-1:0]     w0_data, w1_data;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_regs [NREG];
  bit              m_pend [NREG];
  bit              m_busy;
  int              m_idx;

  always #5 clk = ~clk;

  regfile_mp_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk      (clk),
    .areset   (areset),
    .ra       (ra),
    .rd_data  (rd_data),
    .rd_pend  (rd_pend),
    .w0_en    (w0_en),
    .w0_addr  (w0_addr),
    .w0_data  (w0_data),
    .w1_en    (w1_en),
    .w1_addr  (w1_addr),
    .w1_data  (w1_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .clr_req  (clr_req),
    .clr_busy (clr_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_busy = 1'b0;
    m_idx  = 0;
  endtask

  function automatic logic [31:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (!m_busy && w0_en && w0_addr == a) return w0_data;
    if (!m_busy && w1_en && w1_addr == a) return w1_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_pend(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    return m_pend[a] && !(w1_en && w1_addr == a);
  endfunction

  task automatic check_ports(input string tag);
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] a;
      a = ra[k*AW +: AW];
      checkOutput($sformatf("%s_data%0d_x%0d", tag, k, a), rd_data[k*XLEN +: XLEN], exp_data(a));
      checkOutput($sformatf("%s_pend%0d_x%0d", tag, k, a), {31'b0, rd_pend[k]}, {31'b0, exp_pend(a)});
    end
    checkOutput({tag, "_busy"}, {31'b0, clr_busy}, {31'b0, m_busy});
  endtask

  task automatic applyStimulus(input logic e0, input logic [AW-1:0] a0, input logic [31:0] d0,
                               input logic e1, input logic [AW-1:0] a1, input logic [31:0] d1,
                               input logic iv, input logic [AW-1:0] ir, input logic cr,
                               input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
    w0_en = e0; w0_addr = a0; w0_data = d0;
    w1_en = e1; w1_addr = a1; w1_data = d1;
    iss_valid = iv; iss_rd = ir; clr_req = cr;
    ra = {r1, r0};
    #1;
    check_ports(tag);
  endtask

  task automatic idle_read(input logic [AW-1:0] r0, input logic [AW-1:0] r1, input string tag);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, r0, r1, tag);
  endtask

  // Advance one clock and apply the register file rules to the model
  task automatic tick();
    @(posedge clk);
    if (!m_busy) begin
      if (w0_en && w0_addr != 0) m_regs[w0_addr] = w0_data;
      if (w1_en && w1_addr != 0 && !(w0_en && w0_addr == w1_addr)) m_regs[w1_addr] = w1_data;
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_busy = 1'b1;
        m_idx  = 1;
      end else begin
        if (w1_en && w1_addr != 0) m_pend[w1_addr] = 1'b0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      end
    end else begin
      m_regs[m_idx] = '0;
      if (m_idx == NREG - 1) m_busy = 1'b0;
      else m_idx++;
    end
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NREG - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    areset = 1'b0;
    model_reset();

    // 1: reset state
    idle_read(5, 31, "t1");
    checkOutput("t1_rd0", rd_data[31:0], 32'h0);
    checkOutput("t1_rd1", rd_data[63:32], 32'h0);
    checkOutput("t1_pend", {30'b0, rd_pend}, 32'h0);
    checkOutput("t1_busy", {31'b0, clr_busy}, 32'h0);
    repeat (2) @(posedge clk);
    #2 areset = 1'b1;

    // 2: W0 bypass and x0 hardwired
    applyStimulus(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 7, 0, "t2_byp");
    checkOutput("t2_bypass", rd_data[31:0], 32'hDEADBEEF);
    tick();
    applyStimulus(1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 7, 0, "t2_x0w");
    checkOutput("t2_stored", rd_data[31:0], 32'hDEADBEEF);
    checkOutput("t2_x0_byp", rd_data[63:32], 32'h0);
    tick();
    idle_read(0, 7, "t2_rd");
    checkOutput("t2_x0", rd_data[31:0], 32'h0);

    // 3: issue marks pending, load return clears it with bypass
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 9, "t3_iss");
    tick();
    idle_read(0, 9, "t3_pend");
    checkOutput("t3_pend_set", {31'b0, rd_pend[1]}, 32'h1);
    tick();
    applyStimulus(0, 0, 0, 1, 9, 32'hA5A5A5A5, 0, 0, 0, 0, 9, "t3_ret");
    checkOutput("t3_ret_pend", {31'b0, rd_pend[1]}, 32'h0);
    checkOutput("t3_ret_data", rd_data[63:32], 32'hA5A5A5A5);
    tick();
    idle_read(0, 9, "t3_after");
    checkOutput("t3_after_pend", {31'b0, rd_pend[1]}, 32'h0);
    checkOutput("t3_after_data", rd_data[63:32], 32'hA5A5A5A5);

    // 4: W0/W1 collision and set-beats-clear
    applyStimulus(1, 3, 32'h11, 1, 3, 32'h22, 0, 0, 0, 3, 0, "t4_coll");
    checkOutput("t4_coll_byp", rd_data[31:0], 32'h11);
    tick();
    idle_read(3, 0, "t4_x3");
    checkOutput("t4_x3", rd_data[31:0], 32'h11);
    applyStimulus(0, 0, 0, 1, 4, 32'h44, 1, 4, 0, 0, 4, "t4_setclr");
    tick();
    idle_read(0, 4, "t4_p4");
    checkOutput("t4_pend4", {31'b0, rd_pend[1]}, 32'h1);

    // 5: preload everything, soft clear, ignored write during clear
    for (int i = 1; i < NREG; i++) begin
      applyStimulus(1, AW'(i), 32'h01010101 * i + 32'h100, 0, 0, 0, i[0], AW'(i), 0, AW'(i), AW'(i - 1), "t5_load");
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 31, "t5_req");
    tick();
    n = 0;
    while (clr_busy && n < 100) begin
      applyStimulus(n == 5, 2, 32'hFFFF, 0, 0, 0, 0, 0, 0, 2, AW'($urandom_range(0, NREG - 1)), "t5_clr");
      tick();
      n++;
    end
    checkOutput("t5_clr_len", n, 32'd31);
    for (int i = 0; i < NREG; i += 2) begin
      idle_read(AW'(i), AW'(i + 1), "t5_sweep");
      checkOutput($sformatf("t5_zero_x%0d", i + 1), rd_data[63:32], 32'h0);
      checkOutput($sformatf("t5_npend_x%0d", i + 1), {31'b0, rd_pend[1]}, 32'h0);
    end

    // 6: async reset in the middle of a clear
    applyStimulus(1, 31, 32'h31313131, 1, 10, 32'h10101010, 0, 0, 0, 31, 10, "t6_load");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 31, 10, "t6_req");
    tick();
    for (int c = 1; c < 10; c++) begin
      idle_read(31, 10, "t6_clr");
      tick();
    end
    checkOutput("t6_busy_pre", {31'b0, clr_busy}, 32'h1);
    areset = 1'b0;
    model_reset();
    #1;
    checkOutput("t6_busy_rst", {31'b0, clr_busy}, 32'h0);
    idle_read(31, 10, "t6_rst");
    checkOutput("t6_x31", rd_data[31:0], 32'h0);
    @(posedge clk);
    #2 areset = 1'b1;
    applyStimulus(1, 10, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0, 10, 31, "t6_wr");
    tick();
    idle_read(10, 31, "t6_after");
    checkOutput("t6_write_ok", rd_data[31:0], 32'hCAFEF00D);

    // Random traffic
    for (int c = 0; c < 2000; c++) begin
      applyStimulus($urandom_range(0, 1), rand_addr(), $urandom(),
                    $urandom_range(0, 1), rand_addr(), $urandom(),
                    $urandom_range(0, 1), rand_addr(),
                    $urandom_range(0, 99) == 0,
                    rand_addr(), rand_addr(), "rnd");
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
Parametrised successor to the single-cycle core's register file, for the pipelined core. It provides NRD combinational read ports and two write ports: W0 for ALU writeback and W1 for multicycle load return. It also keeps a per-register pending scoreboard for outstanding loads and runs a sequential soft-clear engine. It sits between decode (reads, issue marking) and writeback/load-return.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREG), register address width (derived, not overridden)
NRD, 2, number of read ports

Ports:
clk  in  1  clock
areset  in  1  reset, asynchronous, active-low
ra  in  NRD*AW  read addresses; port k at bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data; port k at bits [k*XLEN +: XLEN]
rd_pend  out  NRD  pending (load outstanding) flag per read port
w0_en  in  1  ALU writeback enable
w0_addr  in  AW  ALU writeback address
w0_data  in  XLEN  ALU writeback data
w1_en  in  1  load-return write enable
w1_addr  in  AW  load-return address
w1_data  in  XLEN  load-return data
iss_valid  in  1  load issued this cycle; marks iss_rd pending
iss_rd  in  AW  destination of issued load
clr_req  in  1  soft-clear request (level, sampled in IDLE)
clr_busy  out  1  soft clear in progress

Behaviour:
- Reset (areset low, async): all NREG registers = 0, all pending bits = 0, FSM = IDLE, clear counter = 0, clr_busy = 0. Outputs settle to rd_data = 0 and rd_pend = 0.
- Register 0 is hardwired to zero:
  - writes to address 0 are discarded;
  - reads of address 0 return 0 and rd_pend = 0;
  - iss_rd = 0 never sets a pending bit.
- Writes take effect at posedge clk when enabled, the address is nonzero, and the FSM is IDLE.
- Both write ports targeting the same address in the same cycle: W0 data is stored and W1 data is dropped. The W1 pending-clear still applies.
- Reads are combinational with write-first bypass, priority W0 > W1 > array. A read of address a returns w0_data if w0_en && w0_addr==a, else w1_data if w1_en && w1_addr==a, else the array value. Bypass is disabled during CLEAR.
- Scoreboard, applied at posedge in IDLE only:
  - w1_en && w1_addr!=0 clears pend[w1_addr];
  - iss_valid && iss_rd!=0 sets pend[iss_rd];
  - set and clear on the same address in the same cycle: set wins;
  - issue to an already-pending register keeps it pending;
  - W0 writes do not affect pend.
- rd_pend[k] = pend[ra_k] && !(w1_en && w1_addr==ra_k). Data being returned this cycle is reported not pending.
- Soft-clear FSM, states IDLE and CLEAR:
  - IDLE, clr_req=1 at posedge: go to CLEAR, all pend <= 0 at that edge, counter <= 1.
  - CLEAR: each cycle reg[counter] <= 0, counter++. When counter == NREG-1, clear that register and return to IDLE, so CLEAR lasts NREG-1 cycles.
  - clr_busy = 1 exactly while in CLEAR.
  - During CLEAR: w0/w1/iss inputs are ignored and rd_data/rd_pend reflect the array in its partially cleared state. The caller stalls on clr_busy.
  - clr_req held high at return to IDLE starts a new clear on the next edge.
  - areset asserted mid-CLEAR: immediate reset to IDLE with all registers zero.
- No arithmetic beyond the AW-bit counter; the counter never wraps because the exit is at NREG-1.

Decomposition:
- Shared package (regfile_pkg): state enum {IDLE, CLEAR}, ZERO_REG = 0, default XLEN/NREG.
- One natural sub-module, regfile_rd_port: one bypassing read port (address, array row, both write buses -> data, pend). Instantiated NRD times via generate.

Test Plan:
1. Reset, then read ports 0/1 at addresses 5 and 31 -> rd_data = 0, rd_pend = 0; clr_busy = 0.
2. w0 writes 0xDEADBEEF to x7 while ra0=7 in the same cycle -> rd_data0 = 0xDEADBEEF combinationally (bypass) and after the edge. Write 0x1234 to x0 -> reads of x0 stay 0.
3. iss_valid with iss_rd=9, ra1=9 -> rd_pend1 = 1 next cycle. Then w1 writes 0xA5A5A5A5 to x9 -> rd_pend1 = 0 in the same cycle with data bypassed, and stays 0 after the edge.
4. w0 and w1 both write x3 (0x11, 0x22) in one cycle -> x3 = 0x11. Simultaneous iss_rd=4 with w1_addr=4 -> pend[4] = 1.
5. Preload x1..x31 = nonzero, pulse clr_req -> clr_busy high for exactly 31 cycles, all pend = 0 after the first edge, all registers 0 afterwards. A w0 write during CLEAR is ignored.
6. Start clear, assert areset at cycle 10 of CLEAR -> clr_busy = 0 immediately, all registers read 0, FSM IDLE, and a normal write succeeds after release.
